// File: rtl/adc_acq_ctrl.sv
// rtl/adc_acq_ctrl.sv - ADC frame acquisition controller
// Skips a programmed number of frames, then captures frames and serialises enabled channels.
module adc_acq_ctrl #(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   delay_frames,
  input  logic [CW-1:0]   num_frames,
  input  logic [7:0]      ch_mask,
  input  logic            frame_stb,
  input  logic [8*DW-1:0] frame_data,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            overrun,
  output logic [CW-1:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, DELAY, ACQ, DRAIN} state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CW-1:0]   delay_q, delay_d, num_q, num_d;
  logic [CW-1:0]   dcnt_q, dcnt_d, fcnt_q, fcnt_d;
  logic [7:0]      mask_q, mask_d, pend_q, pend_d;
  logic [8*DW-1:0] buf_q, buf_d;
  logic            ovr_q, ovr_d;

  logic [2:0] sel;
  logic [7:0] sel_oh;
  logic       accept;
  logic       buf_free;

  // Lowest pending channel wins the output.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end

  assign sel_oh    = 8'b1 << sel;
  assign out_valid = |pend_q;
  assign accept    = out_valid & out_ready;
  // Free if nothing would remain pending after this cycle's accept.
  assign buf_free  = (pend_q & ~(accept ? sel_oh : 8'h00)) == 8'h00;

  assign out_ch    = sel;
  assign out_data  = out_valid ? buf_q[int'(sel)*DW +: DW] : '0;
  assign busy      = (state_q == DELAY) || (state_q == ACQ);
  assign done      = (state_q == DRAIN) && (pend_q == 8'h00) && !abort;
  assign overrun   = ovr_q;
  assign frame_cnt = fcnt_q;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    num_d   = num_q;
    mask_d  = mask_q;
    dcnt_d  = dcnt_q;
    fcnt_d  = fcnt_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q;
    pend_d  = accept ? (pend_q & ~sel_oh) : pend_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          delay_d = delay_frames;
          num_d   = num_frames;
          mask_d  = ch_mask;
          dcnt_d  = '0;
          fcnt_d  = '0;
          ovr_d   = 1'b0;
          if (num_frames == '0)        state_d = DRAIN;
          else if (delay_frames == '0) state_d = ACQ;
          else                         state_d = DELAY;
        end
      end
      DELAY: begin
        if (frame_stb) begin
          dcnt_d = dcnt_q + ONE;
          if (dcnt_q + ONE == delay_q) state_d = ACQ;
        end
      end
      ACQ: begin
        if (frame_stb) begin
          if (buf_free) begin
            buf_d  = frame_data;
            pend_d = mask_q;
            fcnt_d = fcnt_q + ONE;
            if (fcnt_q + ONE == num_q) state_d = DRAIN;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pend_q == 8'h00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort keeps the counters of the interrupted run for inspection.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pend_d  = 8'h00;
      fcnt_d  = fcnt_q;
      ovr_d   = ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      delay_q <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
      buf_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb/tb_adc_acq_ctrl.sv - directed bench for adc_acq_ctrl
// Vector table of whole acquisitions plus hand-written stall, abort and reset sequences.
module tb_adc_acq_ctrl;
  localparam int DW = 14;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [CW-1:0]   delay_frames = '0;
  logic [CW-1:0]   num_frames = '0;
  logic [7:0]      ch_mask = '0;
  logic            frame_stb = 1'b0;
  logic [8*DW-1:0] frame_data = '0;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_ch;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            done;
  logic            overrun;
  logic [CW-1:0]   frame_cnt;

  always #5 clk = ~clk;

  adc_acq_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_frames(delay_frames), .num_frames(num_frames), .ch_mask(ch_mask),
    .frame_stb(frame_stb), .frame_data(frame_data),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int          done_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_ch, out_data});
    if (done) done_cnt++;
  end

  function automatic logic [DW-1:0] word_of(int f, int ch);
    return DW'(32'h2000 + f * 16 + ch);
  endfunction

  function automatic logic [8*DW-1:0] frame_of(int f);
    logic [8*DW-1:0] r;
    for (int ch = 0; ch < 8; ch++) r[ch*DW +: DW] = word_of(f, ch);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int d, int n, logic [7:0] m);
    delay_frames = CW'(d);
    num_frames   = CW'(n);
    ch_mask      = m;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stb(int f);
    frame_data = frame_of(f);
    frame_stb  = 1'b1;
    tick();
    frame_stb  = 1'b0;
  endtask

  task automatic push_frame(int f, logic [7:0] m);
    for (int ch = 0; ch < 8; ch++)
      if (m[ch]) exp_q.push_back({3'(ch), word_of(f, ch)});
  endtask

  task automatic cmp_words(int base, string name);
    check({name, "_nwords"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < got_q.size()) check({name, "_word"}, 64'(got_q[base+k]), 64'(exp_q[k]));
  endtask

  task automatic wait_done(int d0, int lim, string name);
    int k = 0;
    while (done_cnt == d0 && k < lim) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
  endtask

  typedef struct {
    string      name;
    int         dly;
    int         num;
    logic [7:0] mask;
    int         period;
    int         n_stb;
    int         exp_words;
    int         exp_fc;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base, d0;
    int chs[4];

    vecs[0] = '{"full_ff",  2, 3, 8'hFF, 16, 5, 24, 3, 1'b0};
    vecs[1] = '{"mask_a5",  0, 1, 8'hA5, 16, 1,  4, 1, 1'b0};
    vecs[2] = '{"mask_0",   1, 2, 8'h00, 12, 3,  0, 2, 1'b0};
    vecs[3] = '{"num_0",    4, 0, 8'hFF, 12, 0,  0, 0, 1'b0};
    vecs[4] = '{"extra_stb",0, 2, 8'h80, 10, 4,  2, 2, 1'b0};
    chs = '{0, 2, 5, 7};

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    foreach (vecs[i]) begin
      base = got_q.size();
      d0 = done_cnt;
      exp_q.delete();
      out_ready = 1'b1;
      cfg(vecs[i].dly, vecs[i].num, vecs[i].mask);
      pulse_start();
      for (int s = 0; s < vecs[i].n_stb; s++) begin
        repeat (vecs[i].period - 1) tick();
        stb(s);
      end
      wait_done(d0, 100, vecs[i].name);
      repeat (5) tick();
      for (int f = vecs[i].dly; f < vecs[i].dly + vecs[i].num && f < vecs[i].n_stb; f++)
        push_frame(f, vecs[i].mask);
      check({vecs[i].name, "_tbl_words"}, 64'(got_q.size() - base), 64'(vecs[i].exp_words));
      cmp_words(base, vecs[i].name);
      check({vecs[i].name, "_frame_cnt"}, frame_cnt, 64'(vecs[i].exp_fc));
      check({vecs[i].name, "_overrun"}, overrun, vecs[i].exp_ov);
      check({vecs[i].name, "_done_cnt"}, 64'(done_cnt - d0), 1);
      check({vecs[i].name, "_busy"}, busy, 0);
    end

    // First word one cycle after frame_stb, then back-to-back in channel order.
    d0 = done_cnt;
    cfg(0, 1, 8'hA5);
    pulse_start();
    tick();
    frame_data = frame_of(7);
    frame_stb = 1'b1;
    @(negedge clk);
    check("lat_pre_valid", out_valid, 0);
    tick();
    frame_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lat_valid", out_valid, 1);
      check("lat_ch", out_ch, 64'(chs[k]));
      check("lat_data", out_data, word_of(7, chs[k]));
    end
    @(negedge clk);
    check("lat_post_valid", out_valid, 0);
    wait_done(d0, 20, "lat");

    // Sink stalled across three frames: two dropped, output held.
    base = got_q.size();
    d0 = done_cnt;
    exp_q.delete();
    out_ready = 1'b0;
    cfg(0, 4, 8'hFF);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      repeat (7) tick();
      stb(i);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_ch", out_ch, 0);
      check("stall_data", out_data, word_of(0, 0));
    end
    check("stall_overrun", overrun, 1);
    check("stall_frame_cnt", frame_cnt, 1);
    tick();
    out_ready = 1'b1;
    for (int f = 3; f < 6; f++) begin
      repeat (15) tick();
      stb(f);
    end
    wait_done(d0, 100, "stall");
    push_frame(0, 8'hFF);
    for (int f = 3; f < 6; f++) push_frame(f, 8'hFF);
    cmp_words(base, "stall");
    check("stall_end_overrun", overrun, 1);
    check("stall_end_frame_cnt", frame_cnt, 4);

    // Capture coincident with accept of the last pending word.
    base = got_q.size();
    d0 = done_cnt;
    exp_q.delete();
    cfg(0, 3, 8'h01);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      frame_data = frame_of(10 + i);
      frame_stb = 1'b1;
      tick();
    end
    frame_stb = 1'b0;
    wait_done(d0, 20, "b2b");
    for (int f = 10; f < 13; f++) push_frame(f, 8'h01);
    cmp_words(base, "b2b");
    check("b2b_overrun", overrun, 0);
    check("b2b_frame_cnt", frame_cnt, 3);

    // num=0 completes at once; start while busy is ignored.
    base = got_q.size();
    d0 = done_cnt;
    cfg(0, 0, 8'hFF);
    pulse_start();
    @(negedge clk);
    check("num0_done", done, 1);
    check("num0_valid", out_valid, 0);
    tick();
    exp_q.delete();
    cfg(3, 1, 8'hFF);
    pulse_start();
    @(negedge clk);
    check("ign_busy", busy, 1);
    cfg(0, 5, 8'h01);
    pulse_start();
    for (int f = 20; f < 24; f++) begin
      repeat (11) tick();
      stb(f);
    end
    wait_done(d0 + 1, 50, "ign");
    push_frame(23, 8'hFF);
    cmp_words(base, "ign");
    check("ign_frame_cnt", frame_cnt, 1);
    check("ign_done_cnt", 64'(done_cnt - d0), 2);

    // frame_stb during DRAIN is not an overrun.
    base = got_q.size();
    d0 = done_cnt;
    exp_q.delete();
    out_ready = 1'b0;
    cfg(0, 1, 8'hFF);
    pulse_start();
    stb(30);
    tick();
    stb(31);
    @(negedge clk);
    check("drain_overrun", overrun, 0);
    check("drain_frame_cnt", frame_cnt, 1);
    check("drain_data", out_data, word_of(30, 0));
    tick();
    out_ready = 1'b1;
    wait_done(d0, 30, "drain");
    push_frame(30, 8'hFF);
    cmp_words(base, "drain");

    // Abort mid-ACQ with words pending.
    out_ready = 1'b0;
    cfg(0, 5, 8'hFF);
    pulse_start();
    stb(40);
    tick();
    stb(41);
    tick();
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_frame_cnt", frame_cnt, 1);
    check("abort_overrun", overrun, 1);
    repeat (10) tick();
    check("abort_no_done", 64'(done_cnt - d0), 0);

    // Reset mid-DELAY.
    cfg(5, 2, 8'h03);
    pulse_start();
    stb(50);
    tick();
    @(negedge clk);
    check("dly_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstd_busy", busy, 0);
    check("rstd_valid", out_valid, 0);
    check("rstd_frame_cnt", frame_cnt, 0);

    // Reset mid-ACQ wins over start and frame_stb.
    cfg(0, 3, 8'hFF);
    pulse_start();
    stb(60);
    tick();
    stb(61);
    rst = 1'b1;
    start = 1'b1;
    frame_data = frame_of(62);
    frame_stb = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    frame_stb = 1'b0;
    @(negedge clk);
    check("rsta_valid", out_valid, 0);
    check("rsta_data", out_data, 0);
    check("rsta_ch", out_ch, 0);
    check("rsta_busy", busy, 0);
    check("rsta_done", done, 0);
    check("rsta_overrun", overrun, 0);
    check("rsta_frame_cnt", frame_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_acq_ctrl.md
ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

Interface
REQ-001 Parameter DW, 14, sample width per channel.
REQ-002 Parameter CW, 16, width of delay/sample counters.
REQ-003 clk  in  1  deserializer bit clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin an acquisition.
REQ-006 abort  in  1  one-cycle request to terminate an acquisition.
REQ-007 delay_frames  in  CW  frames skipped after start before capture.
REQ-008 num_frames  in  CW  frames to capture.
REQ-009 ch_mask  in  8  per-channel enable; bit0 = channel A, bit7 = channel H.
REQ-010 frame_stb  in  1  one-cycle pulse per completed 8-channel frame.
REQ-011 frame_data  in  8*DW  channel A in [DW-1:0], channel H in the top DW bits.
REQ-012 out_data  out  DW  sample word.
REQ-013 out_ch  out  3  channel index of out_data (0=A..7=H).
REQ-014 out_valid  out  1  out_data/out_ch valid.
REQ-015 out_ready  in  1  sink accepts the word when high with out_valid.
REQ-016 busy  out  1  high in DELAY or ACQ.
REQ-017 done  out  1  one-cycle pulse on normal completion.
REQ-018 overrun  out  1  sticky: at least one frame dropped.
REQ-019 frame_cnt  out  CW  frames captured in current/last acquisition.

Function
REQ-020 FSM states IDLE, DELAY, ACQ, DRAIN; one state register.
REQ-021 start is honoured only in IDLE; start in any other state is ignored.
REQ-022 On accepted start: latch delay_frames, num_frames, ch_mask; clear frame_cnt and overrun; go DELAY, or ACQ if latched delay is 0.
REQ-023 DELAY: count frame_stb pulses; after the latched delay count of pulses, go ACQ the next cycle; those frames produce no output.
REQ-024 ACQ: on frame_stb with the holding buffer free, capture all 8 channels into the buffer, load pending mask = latched ch_mask, increment frame_cnt.
REQ-025 Buffer is free when pending mask is 0, or exactly one bit is pending and that word is accepted in the same cycle.
REQ-026 frame_stb in ACQ while buffer not free: frame dropped, overrun set, frame_cnt unchanged.
REQ-027 Output arbitration: fixed priority, lowest pending channel index first; one word per accepted handshake.
REQ-028 out_valid asserts the cycle after capture (latency 1 from frame_stb); out_data/out_ch held stable while out_valid and not out_ready.
REQ-029 Accept (out_valid & out_ready) clears that channel's pending bit; next pending word presented the following cycle with no bubble.
REQ-030 Latched ch_mask 0: frames counted, no words emitted.
REQ-031 When frame_cnt reaches the latched num_frames, go DRAIN; further frame_stb ignored (no overrun).
REQ-032 DRAIN: when pending mask becomes 0, pulse done one cycle and go IDLE.
REQ-033 Latched num_frames 0: skip ACQ, go DRAIN, done follows with no words emitted.
REQ-034 abort in DELAY/ACQ/DRAIN: next cycle IDLE, pending cleared, out_valid 0, no done; frame_cnt and overrun retained.
REQ-035 abort and start in the same cycle in IDLE: start wins.
REQ-036 frame_cnt never wraps; it stops at num_frames.

Reset
REQ-037 rst, at any time including mid-frame: state IDLE, out_valid 0, out_data 0, out_ch 0, busy 0, done 0, overrun 0, frame_cnt 0, pending mask 0, latched config 0.
REQ-038 rst has priority over start, abort and frame_stb.

Verification
REQ-039 delay=2, num=3, mask=8'hFF, ready=1, frame_stb every 16 cycles -> 1st/2nd frames skipped, 24 words ch 0..7 x3, frame_cnt=3, one done, overrun=0.
REQ-040 mask=8'b1010_0101, num=1 -> words for ch 0,2,5,7 only, back-to-back, first out_valid one cycle after frame_stb.
REQ-041 ready held low 20 cycles, frame_stb every 8 cycles, mask=8'hFF -> out_data/out_ch stable while stalled, overrun=1, frame_cnt counts only captured frames.
REQ-042 mask=8'h01, frame_stb coincident with accept of last pending word -> new frame captured, no overrun.
REQ-043 num=0 -> done 1-2 cycles after start, no out_valid; start asserted while busy -> ignored.
REQ-044 abort mid-ACQ with words pending, then rst mid-DELAY -> out_valid drops next cycle, no done, all outputs reset values after rst.
